// File: rtl/mux_pkg.sv
// Shared helpers for the handshaked mux responder.
package mux_pkg;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mux_if_responder_if.sv
// Request/response channel bundle between a mux master and the responder.
interface mux_if_responder_if #(
  parameter int DATA_WITH = 8,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
);
  import mux_pkg::*;

  localparam int LVL_W = level_w(DEPTH);

  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [DATA_WITH-1:0] i_a;
  logic [DATA_WITH-1:0] i_b;
  logic                 i_sel;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready;
  logic [DATA_WITH-1:0] o_y;
  logic [LVL_W-1:0]     o_level;
  logic [CNT_W-1:0]     o_done_cnt;

  modport master (
    output i_req_valid, i_a, i_b, i_sel, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_y, o_level, o_done_cnt
  );

  modport slave (
    input  i_req_valid, i_a, i_b, i_sel, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_y, o_level, o_done_cnt
  );

endinterface

// File: rtl/mux_rsp_fifo.sv
// In-order response FIFO: DEPTH entries, wrapping pointers, registered occupancy.
module mux_rsp_fifo
  import mux_pkg::*;
#(
  parameter int DATA_WITH = 8,
  parameter int DEPTH     = 2,
  localparam int LVL_W    = level_w(DEPTH),
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_WITH-1:0] din,
  output logic [DATA_WITH-1:0] dout,
  output logic [LVL_W-1:0]     level,
  output logic                 full,
  output logic                 empty
);

  logic [DATA_WITH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic                 wr_ok;
  logic                 rd_ok;

  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);
  assign wr_ok = push && !full && !srst;
  assign rd_ok = pop && !empty;

  // Storage carries no reset so it can map onto plain RAM; empty gating hides stale words.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (wr_ok && !rd_ok) begin
        level_reg <= level_reg + LVL_W'(1);
      end else if (!wr_ok && rd_ok) begin
        level_reg <= level_reg - LVL_W'(1);
      end
    end
  end

  assign dout  = empty ? '0 : mem_reg[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/mux_if_responder.sv
// Handshaked 2:1 mux responder: selects a/b at accept time and queues results in order.
module mux_if_responder
  import mux_pkg::*;
#(
  parameter int DATA_WITH = 8,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mux_if_responder_if.slave bus
);

  localparam int LVL_W = level_w(DEPTH);

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_WITH-1:0] result;
  logic [DATA_WITH-1:0] head;
  logic [LVL_W-1:0]     level;
  logic [CNT_W-1:0]     done_cnt_reg;

  // Ready depends only on registered occupancy, never on the response side.
  assign bus.o_req_ready = !full;
  assign push            = bus.i_req_valid && !full;
  assign pop             = !empty && bus.i_rsp_ready;
  assign result          = bus.i_sel ? bus.i_b : bus.i_a;

  mux_rsp_fifo #(
    .DATA_WITH (DATA_WITH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .srst  (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (result),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_cnt_reg <= '0;
    end else if (pop) begin
      done_cnt_reg <= done_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.o_rsp_valid = !empty;
  assign bus.o_y         = head;
  assign bus.o_level     = level;
  assign bus.o_done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_mux_if_responder.sv
// Directed plus random checks of mux_if_responder against a queue-based model.
module tb_mux_if_responder;

  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [DW-1:0] q[$];
  int unsigned   cnt_model;

  mux_if_responder_if #(.DATA_WITH(DW), .DEPTH(DEPTH), .CNT_W(16)) bus ();
  mux_if_responder_if #(.DATA_WITH(DW), .DEPTH(DEPTH), .CNT_W(4))  bus4 ();

  mux_if_responder #(.DATA_WITH(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  mux_if_responder #(.DATA_WITH(DW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs with the model, apply one clock of stimulus, then advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic s, input logic rr);
    bit do_push;
    bit do_pop;
    chk("req_ready", {31'd0, bus.o_req_ready}, {31'd0, q.size() < DEPTH});
    chk("rsp_valid", {31'd0, bus.o_rsp_valid}, {31'd0, q.size() != 0});
    chk("level", 32'(bus.o_level), 32'(q.size()));
    chk("done_cnt", 32'(bus.o_done_cnt), cnt_model % 65536);
    if (q.size() != 0) chk("y", 32'(bus.o_y), 32'(q[0]));
    do_push = v && (q.size() < DEPTH);
    do_pop  = rr && (q.size() != 0);
    bus.i_req_valid = v;
    bus.i_a         = a;
    bus.i_b         = b;
    bus.i_sel       = s;
    bus.i_rsp_ready = rr;
    @(posedge clk);
    #1;
    if (do_pop) begin
      $display("pop  y=%02h done=%0d", q[0], cnt_model + 1);
      void'(q.pop_front());
      cnt_model++;
    end
    if (do_push) begin
      q.push_back(s ? b : a);
      $display("push y=%02h", s ? b : a);
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_a         = DW'($urandom);
    bus.i_b         = DW'($urandom);
    bus.i_sel       = 1'($urandom);
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    cnt_model = 0;
    chk("rst_req_ready", {31'd0, bus.o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("rst_y", 32'(bus.o_y), 32'd0);
    chk("rst_level", 32'(bus.o_level), 32'd0);
    chk("rst_done_cnt", 32'(bus.o_done_cnt), 32'd0);
    rst = 1'b0;
    bus.i_req_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cnt_model = 0;
    rst = 1'b1;
    bus.i_req_valid  = 1'b0;
    bus.i_a          = '0;
    bus.i_b          = '0;
    bus.i_sel        = 1'b0;
    bus.i_rsp_ready  = 1'b0;
    bus4.i_req_valid = 1'b0;
    bus4.i_a         = '0;
    bus4.i_b         = '0;
    bus4.i_sel       = 1'b0;
    bus4.i_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a valid request pending: nothing may be pushed.
    do_reset();
    chk("rst_release_ready", {31'd0, bus.o_req_ready}, 32'd1);

    // Single transactions.
    cycle(1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1);
    chk("single_y_sel1", 32'(bus.o_y), 32'h0A5);
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);
    chk("single_done1", 32'(bus.o_done_cnt), 32'd1);
    cycle(1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1);
    chk("single_y_sel0", 32'(bus.o_y), 32'h03C);
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);

    // Idle with garbage operands must not change state.
    repeat (3) cycle(1'b0, DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));

    // Back-pressure until full, third request held, then drain in order.
    cycle(1'b1, 8'h11, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 8'hEE, 1'b0, 1'b0);
    chk("full_level", 32'(bus.o_level), 32'd2);
    chk("full_ready", {31'd0, bus.o_req_ready}, 32'd0);
    cycle(1'b1, 8'h33, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 8'hEE, 1'b0, 1'b0);
    chk("held_head", 32'(bus.o_y), 32'h011);
    cycle(1'b1, 8'h33, 8'hEE, 1'b0, 1'b1);
    chk("after_pop_ready", {31'd0, bus.o_req_ready}, 32'd1);
    cycle(1'b1, 8'h33, 8'hEE, 1'b0, 1'b1);
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);

    // Random back-pressure mix.
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
    end

    // Streaming: 100 back-to-back requests with the response side always ready.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, DW'($urandom), DW'($urandom), 1'($urandom), 1'b1);
    end
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);
    chk("stream_done", 32'(bus.o_done_cnt), 32'd100);
    chk("stream_empty", {31'd0, bus.o_rsp_valid}, 32'd0);

    // Reset while two responses are queued.
    cycle(1'b1, 8'h5A, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 8'h6B, 1'b1, 1'b0);
    chk("pre_rst_level", 32'(bus.o_level), 32'd2);
    do_reset();
    cycle(1'b1, 8'h77, 8'h88, 1'b1, 1'b0);
    chk("post_rst_y", 32'(bus.o_y), 32'h088);
    chk("post_rst_level", 32'(bus.o_level), 32'd1);
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);
    cycle(1'b0, 'x, 'x, 1'bx, 1'b1);

    // Narrow counter wraps after 17 pops.
    for (int i = 0; i < 17; i++) begin
      bus4.i_req_valid = 1'b1;
      bus4.i_a         = DW'($urandom);
      bus4.i_b         = DW'($urandom);
      bus4.i_sel       = 1'($urandom);
      bus4.i_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus4.i_req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_done_cnt", 32'(bus4.o_done_cnt), 32'd1);
    chk("wrap_level", 32'(bus4.o_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
